// File: rtl/speed_ramp_ctrl_if.sv
// Command/status bundle for speed_ramp_ctrl: per-channel speed commands in,
// ramped speeds, directions and settle flags out.
interface speed_ramp_ctrl_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 2
);
  logic [3*CHANNELS-1:0]     bin_speed;
  logic                      cmd_valid;
  logic                      estop;
  logic [WIDTH*CHANNELS-1:0] real_speed;
  logic [CHANNELS-1:0]       direction;
  logic [CHANNELS-1:0]       at_target;
  logic                      busy;

  modport master (
    output bin_speed, cmd_valid, estop,
    input  real_speed, direction, at_target, busy
  );

  modport slave (
    input  bin_speed, cmd_valid, estop,
    output real_speed, direction, at_target, busy
  );
endinterface

// File: rtl/speed_ramp_ctrl.sv
// Multi-channel wheel-speed decoder with per-tick acceleration limiting and
// ramp-through-zero reversal. Define SPEED_RAMP_ESTOP_EN to enable emergency stop.
module speed_ramp_ctrl #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned MAX_SPEED = 1000,
  parameter int unsigned STEP      = 10,
  parameter int unsigned TICK_DIV  = 1000
) (
  input logic              clk,
  input logic              rst_n,
  speed_ramp_ctrl_if.slave bus
);

  typedef enum logic [1:0] {HOLD, RAMP_UP, RAMP_DOWN, REVERSE} ramp_state_e;

  localparam int unsigned    CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [WIDTH-1:0] LVL1 = WIDTH'(MAX_SPEED / 3);
  localparam logic [WIDTH-1:0] LVL2 = WIDTH'(MAX_SPEED / 2);
  localparam logic [WIDTH-1:0] LVL3 = WIDTH'(MAX_SPEED);
  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);
  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);

`ifdef SPEED_RAMP_ESTOP_EN
  logic estop_on;
  assign estop_on = bus.estop;
`else
  localparam logic estop_on = 1'b0;
`endif

  logic [CW-1:0] cnt_q;
  logic          tick;

  logic [WIDTH-1:0] spd_q [CHANNELS];
  logic [WIDTH-1:0] spd_n [CHANNELS];
  logic [WIDTH-1:0] tgt_q [CHANNELS];
  logic [WIDTH-1:0] tgt_n [CHANNELS];
  ramp_state_e      st_q  [CHANNELS];
  ramp_state_e      st_n  [CHANNELS];
  logic [CHANNELS-1:0] tdir_q, tdir_n;
  logic [CHANNELS-1:0] dir_q, dir_n;
  logic [CHANNELS-1:0] at_q, at_n;
  logic                busy_q, busy_n;

  function automatic logic [WIDTH-1:0] lvl_speed(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return '0;
      2'd1:    return LVL1;
      2'd2:    return LVL2;
      default: return LVL3;
    endcase
  endfunction

  // Comparisons are made one bit wider so neither step direction can wrap.
  function automatic logic [WIDTH-1:0] step_speed(input ramp_state_e st,
                                                  input logic [WIDTH-1:0] spd,
                                                  input logic [WIDTH-1:0] tgt);
    case (st)
      RAMP_UP:   return (({1'b0, spd} + STEP_W) > {1'b0, tgt}) ? tgt : spd + STEP_N;
      RAMP_DOWN: return ({1'b0, spd} >= ({1'b0, tgt} + STEP_W)) ? spd - STEP_N : tgt;
      REVERSE:   return ({1'b0, spd} > STEP_W) ? spd - STEP_N : '0;
      default:   return spd;
    endcase
  endfunction

  function automatic ramp_state_e classify(input logic [WIDTH-1:0] spd,
                                           input logic [WIDTH-1:0] tgt,
                                           input logic dir,
                                           input logic tdir);
    if (dir != tdir && spd != '0) return REVERSE;
    if (spd < tgt)                return RAMP_UP;
    if (spd > tgt)                return RAMP_DOWN;
    return HOLD;
  endfunction

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= tick ? '0 : cnt_q + CW'(1);
  end

  // The step on an edge always uses the registered target and state; a
  // command on the same edge only takes effect from the following tick.
  always_comb begin
    tdir_n = tdir_q;
    dir_n  = dir_q;
    at_n   = '1;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      spd_n[i] = spd_q[i];
      tgt_n[i] = tgt_q[i];
      st_n[i]  = st_q[i];
      if (estop_on) begin
        spd_n[i] = '0;
        tgt_n[i] = '0;
        st_n[i]  = HOLD;
      end else begin
        if (tick) spd_n[i] = step_speed(st_q[i], spd_q[i], tgt_q[i]);
        if (bus.cmd_valid) begin
          tgt_n[i]  = lvl_speed(bus.bin_speed[3*i +: 2]);
          tdir_n[i] = bus.bin_speed[3*i + 2];
        end
        // Direction only ever changes at standstill: a command at zero or
        // the edge on which a reversal reaches zero.
        if (spd_n[i] == '0 && (bus.cmd_valid || (tick && st_q[i] == REVERSE)))
          dir_n[i] = tdir_n[i];
        st_n[i] = classify(spd_n[i], tgt_n[i], dir_n[i], tdir_n[i]);
      end
      at_n[i] = (st_n[i] == HOLD);
    end
  end

  assign busy_n = ~&at_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        spd_q[i] <= '0;
        tgt_q[i] <= '0;
        st_q[i]  <= HOLD;
      end
      tdir_q <= '0;
      dir_q  <= '0;
      at_q   <= '1;
      busy_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        spd_q[i] <= spd_n[i];
        tgt_q[i] <= tgt_n[i];
        st_q[i]  <= st_n[i];
      end
      tdir_q <= tdir_n;
      dir_q  <= dir_n;
      at_q   <= at_n;
      busy_q <= busy_n;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign bus.real_speed[WIDTH*g +: WIDTH] = spd_q[g];
  end
  assign bus.direction = dir_q;
  assign bus.at_target = at_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_speed_ramp_ctrl.sv
// Self-checking bench for speed_ramp_ctrl: directed scenarios plus random
// commands, compared every cycle against a move-toward-goal reference model.
module tb_speed_ramp_ctrl;
  localparam int W  = 16;
  localparam int C  = 2;
  localparam int MS = 1000;
  localparam int ST = 100;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  speed_ramp_ctrl_if #(.WIDTH(W), .CHANNELS(C)) bus ();

  speed_ramp_ctrl #(
    .WIDTH(W), .CHANNELS(C), .MAX_SPEED(MS), .STEP(ST), .TICK_DIV(TD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int cyc_n    = 0;

  // Reference model: speed, target and directions per wheel, plus tick phase.
  int m_spd [C];
  int m_tgt [C];
  bit m_dir [C];
  bit m_tdir[C];
  int m_cnt;

  int rec_v[$];
  int rec_t[$];
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic int lvl_val(input int l);
    case (l)
      0:       return 0;
      1:       return MS / 3;
      2:       return MS / 2;
      default: return MS;
    endcase
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < C; c++) begin
      m_spd[c] = 0; m_tgt[c] = 0; m_dir[c] = 0; m_tdir[c] = 0;
    end
    m_cnt = 0;
  endfunction

  function automatic void model_edge();
    bit tk, es, rev;
    int prev, goal;
    if (!rst_n) begin
      model_reset();
      return;
    end
`ifdef SPEED_RAMP_ESTOP_EN
    es = bus.estop;
`else
    es = 1'b0;
`endif
    tk = (m_cnt == TD - 1);
    m_cnt = tk ? 0 : m_cnt + 1;
    for (int c = 0; c < C; c++) begin
      if (es) begin
        m_spd[c] = 0;
        m_tgt[c] = 0;
        continue;
      end
      prev = m_spd[c];
      // Heading the wrong way means the real goal is standstill.
      goal = (m_dir[c] == m_tdir[c]) ? m_tgt[c] : 0;
      rev  = tk && (m_dir[c] != m_tdir[c]) && prev > 0;
      if (tk) begin
        if (prev < goal)      m_spd[c] = (prev + ST < goal) ? prev + ST : goal;
        else if (prev > goal) m_spd[c] = (prev - ST > goal) ? prev - ST : goal;
      end
      if (bus.cmd_valid) begin
        m_tgt[c]  = lvl_val(int'(bus.bin_speed[3*c +: 2]));
        m_tdir[c] = bus.bin_speed[3*c + 2];
      end
      if (m_spd[c] == 0 && (bus.cmd_valid || rev)) m_dir[c] = m_tdir[c];
    end
  endfunction

  function automatic int spd_of(input int ch);
    return int'(bus.real_speed[W*ch +: W]);
  endfunction

  task automatic compare_all();
    bit any_busy = 1'b0;
    bit at_c;
    for (int c = 0; c < C; c++) begin
      at_c = (m_spd[c] == m_tgt[c]) && (m_dir[c] == m_tdir[c] || m_spd[c] == 0);
      any_busy |= !at_c;
      check($sformatf("spd%0d", c), bus.real_speed[W*c +: W], m_spd[c]);
      check($sformatf("dir%0d", c), bus.direction[c], m_dir[c]);
      check($sformatf("at%0d", c), bus.at_target[c], at_c);
    end
    check("busy", bus.busy, any_busy);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    cyc_n++;
    compare_all();
  endtask

  task automatic command(input logic [5:0] b);
    bus.bin_speed = b;
    bus.cmd_valid = 1'b1;
    cyc();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic record(input int ch, input int ncyc);
    int last;
    rec_v.delete();
    rec_t.delete();
    last = spd_of(ch);
    repeat (ncyc) begin
      cyc();
      if (spd_of(ch) != last) begin
        last = spd_of(ch);
        rec_v.push_back(last);
        rec_t.push_back(cyc_n);
      end
    end
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, rec_v.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_%0d", tag, i), (i < rec_v.size()) ? rec_v[i] : -1, exp_q[i]);
  endtask

  task automatic wait_speed(input int ch, input int val, input int max_cyc);
    int n = 0;
    while (spd_of(ch) != val && n < max_cyc) begin
      cyc();
      n++;
    end
    check($sformatf("wait%0d_%0d", ch, val), spd_of(ch), val);
  endtask

  initial begin
    bus.bin_speed = '0;
    bus.cmd_valid = 1'b0;
    bus.estop     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Idle after reset
    repeat (20) cyc();
    check("idle_busy", bus.busy, 0);
    check("idle_at", bus.at_target, 2'b11);

    // Ramp ch0 to level 1: one step per 4 clocks, capped at 333
    command(6'b000_001);
    record(0, 24);
    exp_q = '{100, 200, 300, 333};
    check_seq("lvl1");
    for (int i = 1; i < 4 && i < rec_t.size(); i++)
      check($sformatf("lvl1_gap%0d", i), rec_t[i] - rec_t[i-1], TD);
    check("lvl1_at0", bus.at_target[0], 1);
    check("lvl1_ch1", spd_of(1), 0);

    // Reversal from 500 forward to 500 reverse, through zero
    command(6'b000_010);
    wait_speed(0, 500, 20);
    command(6'b000_110);
    record(0, 60);
    exp_q = '{400, 300, 200, 100, 0, 100, 200, 300, 400, 500};
    check_seq("rev");
    check("rev_dir0", bus.direction[0], 1);

    // Retarget ch1 mid-ramp at 700 down to 500
    command(6'b011_110);
    wait_speed(1, 700, 40);
    command(6'b010_110);
    record(1, 20);
    exp_q = '{600, 500};
    check_seq("retgt");
    check("retgt_at1", bus.at_target[1], 1);

    // Command landing exactly on a tick edge: that step uses the old target
    command(6'b011_110);
    wait_speed(1, 800, 30);
    for (int n = 0; n < TD && m_cnt != TD - 1; n++) cyc();
    command(6'b001_110);
    check("tick_edge_old_tgt", spd_of(1), 900);
    record(1, 40);
    exp_q = '{800, 700, 600, 500, 400, 333};
    check_seq("tick_edge");

    // Asynchronous reset mid-ramp at 300 with direction 1
    command(6'b001_100);
    wait_speed(0, 300, 20);
    rst_n = 1'b0;
    #1;
    check("rst_spd0", spd_of(0), 0);
    check("rst_spd1", spd_of(1), 0);
    check("rst_dir", bus.direction, 2'b00);
    check("rst_at", bus.at_target, 2'b11);
    check("rst_busy", bus.busy, 0);
    model_reset();
    cyc();
    rst_n = 1'b1;
    command(6'b000_001);
    cyc();
    cyc();
    check("first_tick_pre", spd_of(0), 0);
    cyc();
    check("first_tick", spd_of(0), 100);

    // Emergency stop at full speed, direction 1
    command(6'b000_111);
    wait_speed(0, 1000, 100);
    bus.estop = 1'b1;
    command(6'b000_001);
`ifdef SPEED_RAMP_ESTOP_EN
    check("estop_spd", spd_of(0), 0);
    check("estop_dir_held", bus.direction[0], 1);
`else
    check("estop_ignored", spd_of(0) >= 900, 1);
`endif
    bus.cmd_valid = 1'b1;
    repeat (3) cyc();
    bus.cmd_valid = 1'b0;
    bus.estop = 1'b0;
    repeat (12) cyc();
`ifdef SPEED_RAMP_ESTOP_EN
    check("estop_stays0", spd_of(0), 0);
`endif

    // Random commands and estop pulses
    repeat (800) begin
      bus.cmd_valid = ($urandom_range(0, 9) == 0);
      bus.bin_speed = 6'($urandom);
      bus.estop     = ($urandom_range(0, 79) == 0);
      cyc();
    end
    bus.cmd_valid = 1'b0;
    bus.estop = 1'b0;
    repeat (60) cyc();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
